decode_stage: RTL and testbench
===============================

# decode_stage

Decode stage of the RISC-V core, feeding the arithmetic logic unit. It accepts raw 32-bit instruction words from fetch over a valid/ready handshake and decodes the opcode and funct3 into an `instruction_t`. It reads source operands from an internal register file and selects register or immediate operands. The result is held in a single pipeline register that presents `input1`/`input2`-ready operands to execute.

## Interface
Parameters:
- `REGISTER_WIDTH`, from `common` (32): operand and register width.
- `REGISTER_COUNT`, 32: architectural registers; x0 reads as zero.

Ports:
- `clk` in 1: single clock. All state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `fetch_valid` in 1: `fetch_instruction` is valid.
- `fetch_ready` out 1: stage accepts this cycle.
- `fetch_instruction` in 32: raw instruction word.
- `decode_valid` out 1: decoded outputs are valid.
- `decode_ready` in 1: execute consumes this cycle.
- `decoded_instruction` out `instruction_t`: opcode plus instruction fields.
- `operand1` out REGISTER_WIDTH: value of rs1.
- `operand2` out REGISTER_WIDTH: value of rs2, or the sign-extended I-immediate.
- `rd_address` out 5: destination register.
- `illegal` out 1: opcode is neither OP_ARITHMETIC nor OP_ARITHMETIC_IMMEDIATE.
- `wb_enable` in 1: writeback write strobe.
- `wb_address` in 5: writeback destination.
- `wb_data` in REGISTER_WIDTH: writeback value.
- `flush` in 1: discard the held instruction.

## Operation
- Handshake: `fetch_ready = !decode_valid || decode_ready` (combinational). Accept when `fetch_valid && fetch_ready`.
- Accept:
  - Latch the decoded fields and `rd_address`.
  - `operand1 = reg[rs1]`.
  - For OP_ARITHMETIC: `operand2 = reg[rs2]`.
  - For OP_ARITHMETIC_IMMEDIATE: `operand2 = {{20{instr[31]}}, instr[31:20]}`, sign-extended to REGISTER_WIDTH. Shifts use the same value; the ALU uses [4:0].
  - For any other opcode: `illegal=1`, `operand1=operand2=0`. The instruction is still presented.
- `decode_valid` register:
  - Set on accept.
  - Cleared when `decode_ready && !accept`.
  - Held otherwise.
- While `decode_valid && !decode_ready`, all outputs are stable. There is one exception: operand snoop.
- Operand snoop: while holding, if `wb_enable && wb_address != 0` matches the captured rs1 or rs2, the matching operand register is updated with `wb_data`. This does not apply to an immediate operand2.
- Register file:
  - Write `reg[wb_address] <= wb_data` when `wb_enable && wb_address != 0`.
  - Writes to x0 are ignored; x0 always reads 0.
  - Same-cycle bypass: a read of an address being written this cycle (nonzero) returns `wb_data`.
- Flush:
  - Next cycle `decode_valid=0`.
  - A same-cycle accept is discarded; flush has priority.
  - Register file writes during flush still occur.
- Reset (synchronous, dominates everything):
  - `decode_valid`, `illegal`, `operand1`, `operand2`, `rd_address` and `decoded_instruction` all go to 0.
  - All registers are cleared to 0.
  - A held instruction is dropped; the pending handshake is lost.
  - While `reset=1`, `fetch_ready` still follows its equation.

## Timing
- Latency: 1 cycle from accept to `decode_valid`.
- Throughput: 1 instruction per cycle when `decode_ready=1`.
- Register write: visible to a read in the same cycle via the bypass, and in the register array from the next cycle.
- No combinational path from `fetch_*` to `decode_*`.
- `fetch_ready` depends combinationally on `decode_ready` only.

## Structure
- `common` package: `REGISTER_WIDTH`, `instruction_t` (opcode, `instr` union with `i_type`/`r_type` fields), opcode constants, funct3 enums. Add `REGISTER_COUNT` and a `register_address_t` (5-bit) typedef there.
- Sub-module `register_file`:
  - 2 asynchronous read ports, 1 synchronous write port.
  - Write bypass and x0 handling.
  - Synchronous reset clears the array.
- Handshake, immediate generation and snoop logic live in `decode_stage`.

## Test plan
- Reset, then x5=7 via writeback. Feed `addi x1,x5,-3` → next cycle `decode_valid=1`, `operand1=7`, `operand2=0xFFFFFFFD`, `rd_address=1`, `illegal=0`.
- `add x3,x1,x2` with x1=10, x2=20 while `decode_ready=0` for 3 cycles → outputs stable, `fetch_ready=0`. Raise `decode_ready` → consumed, next accepted the same cycle.
- Writeback x2=99 in the same cycle as accepting `add x3,x2,x0` → `operand1=99` (bypass), `operand2=0`.
- Hold `add x3,x1,x2` stalled, then writeback x1=55 → `operand1` becomes 55 next cycle; `operand2` unchanged.
- Writeback x0=123, then `addi x4,x0,0` → `operand1=0`.
- Opcode 0x63 → `illegal=1`. Assert `flush` during a stall → `decode_valid=0` next cycle. Assert `reset` while holding → all outputs 0 and x5 reads 0.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// common: shared core types (register width, instruction layout, opcodes, funct3 codes)
package common;

    localparam int REGISTER_WIDTH = 32;
    localparam int REGISTER_COUNT = 32;

    typedef logic [4:0] register_address_t;
    typedef logic [6:0] opcode_t;

    localparam opcode_t OP_ARITHMETIC           = 7'h33;
    localparam opcode_t OP_ARITHMETIC_IMMEDIATE = 7'h13;

    typedef enum logic [2:0] {
        F3_ADD_SUB = 3'd0,
        F3_SLL     = 3'd1,
        F3_SLT     = 3'd2,
        F3_SLTU    = 3'd3,
        F3_XOR     = 3'd4,
        F3_SRL_SRA = 3'd5,
        F3_OR      = 3'd6,
        F3_AND     = 3'd7
    } funct3_t;

    typedef struct packed {
        logic [11:0]       immediate;
        register_address_t rs1;
        funct3_t           funct3;
        register_address_t rd;
    } i_type_t;

    typedef struct packed {
        logic [6:0]        funct7;
        register_address_t rs2;
        register_address_t rs1;
        funct3_t           funct3;
        register_address_t rd;
    } r_type_t;

    typedef union packed {
        i_type_t i_type;
        r_type_t r_type;
    } instruction_fields_t;

    typedef struct packed {
        opcode_t             opcode;
        instruction_fields_t instr;
    } instruction_t;

    // Field views over bits [31:7] line up with the raw word, so a rotate is enough.
    function automatic instruction_t to_instruction(input logic [31:0] word);
        return {word[6:0], word[31:7]};
    endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// register_file: 2 async read ports, 1 sync write port, write bypass, x0 hardwired to zero
//   clk, reset          : clock, synchronous active-high reset (clears the array)
//   read_address1/2     : read ports, read_data1/2 combinational
//   write_enable/address/data : write port, ignored for x0
module register_file #(
    parameter int WIDTH = 32,
    parameter int COUNT = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       read_address1,
    input  logic [4:0]       read_address2,
    output logic [WIDTH-1:0] read_data1,
    output logic [WIDTH-1:0] read_data2,
    input  logic             write_enable,
    input  logic [4:0]       write_address,
    input  logic [WIDTH-1:0] write_data
);

    logic [WIDTH-1:0] regs [COUNT];
    logic             write_live;

    assign write_live = write_enable && write_address != '0;

    always_comb begin
        read_data1 = read_address1 == '0 ? '0 :
                     (write_live && write_address == read_address1) ? write_data : regs[read_address1];
        read_data2 = read_address2 == '0 ? '0 :
                     (write_live && write_address == read_address2) ? write_data : regs[read_address2];
    end

    always_ff @(posedge clk) begin
        if (reset)
            regs <= '{default: '0};
        else if (write_live)
            regs[write_address] <= write_data;
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decodes fetched instructions, reads operands and holds them in one pipeline register
//   fetch_valid/fetch_ready/fetch_instruction : input handshake from fetch
//   decode_valid/decode_ready                 : output handshake to execute
//   decoded_instruction, operand1, operand2, rd_address, illegal : registered decode results
//   wb_enable/wb_address/wb_data              : register file write port, also snooped into held operands
//   flush                                     : drops the held instruction and any same-cycle accept
module decode_stage #(
    parameter int REGISTER_WIDTH = common::REGISTER_WIDTH,
    parameter int REGISTER_COUNT = common::REGISTER_COUNT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fetch_valid,
    output logic                      fetch_ready,
    input  logic [31:0]               fetch_instruction,
    output logic                      decode_valid,
    input  logic                      decode_ready,
    output common::instruction_t      decoded_instruction,
    output logic [REGISTER_WIDTH-1:0] operand1,
    output logic [REGISTER_WIDTH-1:0] operand2,
    output common::register_address_t rd_address,
    output logic                      illegal,
    input  logic                      wb_enable,
    input  common::register_address_t wb_address,
    input  logic [REGISTER_WIDTH-1:0] wb_data,
    input  logic                      flush
);

    common::instruction_t      fetched;
    logic [REGISTER_WIDTH-1:0] rs1_data, rs2_data, immediate;
    logic                      is_register_op, is_immediate_op, take, snoop;

    always_comb begin
        fetched         = common::to_instruction(fetch_instruction);
        is_register_op  = fetched.opcode == common::OP_ARITHMETIC;
        is_immediate_op = fetched.opcode == common::OP_ARITHMETIC_IMMEDIATE;
        immediate       = {{(REGISTER_WIDTH-12){fetch_instruction[31]}}, fetch_instruction[31:20]};
        fetch_ready     = !decode_valid || decode_ready;
        take            = fetch_valid && fetch_ready && !flush;
        // Held operands track writebacks so a stalled instruction never issues stale values.
        snoop           = decode_valid && !decode_ready && !illegal && wb_enable && wb_address != '0;
    end

    register_file #(
        .WIDTH(REGISTER_WIDTH),
        .COUNT(REGISTER_COUNT)
    ) u_register_file (
        .clk           (clk),
        .reset         (reset),
        .read_address1 (fetched.instr.r_type.rs1),
        .read_address2 (fetched.instr.r_type.rs2),
        .read_data1    (rs1_data),
        .read_data2    (rs2_data),
        .write_enable  (wb_enable),
        .write_address (wb_address),
        .write_data    (wb_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            decode_valid        <= 1'b0;
            decoded_instruction <= '0;
            operand1            <= '0;
            operand2            <= '0;
            rd_address          <= '0;
            illegal             <= 1'b0;
        end else begin
            decode_valid <= take ? 1'b1 : (flush || decode_ready) ? 1'b0 : decode_valid;
            if (take) begin
                decoded_instruction <= fetched;
                rd_address          <= fetched.instr.r_type.rd;
                illegal             <= !(is_register_op || is_immediate_op);
                operand1            <= (is_register_op || is_immediate_op) ? rs1_data : '0;
                operand2            <= is_register_op ? rs2_data : is_immediate_op ? immediate : '0;
            end else if (snoop) begin
                if (wb_address == decoded_instruction.instr.r_type.rs1)
                    operand1 <= wb_data;
                if (wb_address == decoded_instruction.instr.r_type.rs2 &&
                    decoded_instruction.opcode == common::OP_ARITHMETIC)
                    operand2 <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed plan plus randomized traffic checked against a cycle-level reference model
module tb_decode_stage;

    logic                 clk = 1'b0;
    logic                 reset, fetch_valid, fetch_ready, decode_valid, decode_ready;
    logic                 illegal, wb_enable, flush;
    logic [31:0]          fetch_instruction, operand1, operand2, wb_data;
    logic [4:0]           rd_address, wb_address;
    common::instruction_t decoded_instruction;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_word, m_op1, m_op2;
    logic [4:0]  m_rd;
    logic        m_valid = 1'b0, m_ill = 1'b0, m_known = 1'b0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .fetch_valid         (fetch_valid),
        .fetch_ready         (fetch_ready),
        .fetch_instruction   (fetch_instruction),
        .decode_valid        (decode_valid),
        .decode_ready        (decode_ready),
        .decoded_instruction (decoded_instruction),
        .operand1            (operand1),
        .operand2            (operand2),
        .rd_address          (rd_address),
        .illegal             (illegal),
        .wb_enable           (wb_enable),
        .wb_address          (wb_address),
        .wb_data             (wb_data),
        .flush               (flush)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_op(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    function automatic logic [31:0] i_op(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction

    function automatic logic [31:0] read_reg(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                             input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    task automatic step(input logic r, input logic fv, input logic [31:0] ins, input logic dr,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic fl);
        logic       acc;
        logic [6:0] op;
        reset = r; fetch_valid = fv; fetch_instruction = ins; decode_ready = dr;
        wb_enable = we; wb_address = wa; wb_data = wd; flush = fl;
        #1;
        if (m_known) check("fetch_ready", {31'b0, fetch_ready}, {31'b0, !m_valid || dr});
        if (r) begin
            m_valid = 0; m_ill = 0; m_word = 0; m_op1 = 0; m_op2 = 0; m_rd = 0; m_known = 1;
            foreach (m_regs[i]) m_regs[i] = 0;
        end else begin
            acc = fv && (!m_valid || dr);
            op  = ins[6:0];
            if (acc && !fl) begin
                m_word = ins;
                m_rd   = ins[11:7];
                m_ill  = !(op == 7'h33 || op == 7'h13);
                m_op1  = m_ill ? 32'h0 : read_reg(ins[19:15], we, wa, wd);
                m_op2  = op == 7'h33 ? read_reg(ins[24:20], we, wa, wd) :
                         op == 7'h13 ? {{20{ins[31]}}, ins[31:20]} : 32'h0;
            end else if (m_valid && !dr && !m_ill && we && wa != 0) begin
                if (wa == m_word[19:15]) m_op1 = wd;
                if (m_word[6:0] == 7'h33 && wa == m_word[24:20]) m_op2 = wd;
            end
            m_valid = (acc && !fl) ? 1'b1 : (fl || dr) ? 1'b0 : m_valid;
            if (we && wa != 0) m_regs[wa] = wd;
        end
        @(negedge clk);
        check("decode_valid", {31'b0, decode_valid}, {31'b0, m_valid});
        check("illegal", {31'b0, illegal}, {31'b0, m_ill});
        check("rd_address", {27'b0, rd_address}, {27'b0, m_rd});
        check("operand1", operand1, m_op1);
        check("operand2", operand2, m_op2);
        check("decoded", decoded_instruction, {m_word[6:0], m_word[31:7]});
    endtask

    initial begin
        @(negedge clk);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        check("rst_valid", {31'b0, decode_valid}, 32'd0);
        check("rst_op1", operand1, 32'd0);
        step(0, 0, 0, 1, 1, 5, 7, 0);
        step(0, 1, i_op(1, 5, 12'hFFD), 0, 0, 0, 0, 0);
        check("addi_valid", {31'b0, decode_valid}, 32'd1);
        check("addi_op1", operand1, 32'd7);
        check("addi_op2", operand2, 32'hFFFF_FFFD);
        check("addi_rd", {27'b0, rd_address}, 32'd1);
        check("addi_ill", {31'b0, illegal}, 32'd0);
        step(0, 0, 0, 0, 1, 1, 10, 0);
        step(0, 0, 0, 0, 1, 2, 20, 0);
        check("addi_held_op1", operand1, 32'd7);
        step(0, 1, r_op(3, 1, 2), 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, r_op(5, 6, 7), 0, 0, 0, 0, 0);
            check("stall_ready", {31'b0, fetch_ready}, 32'd0);
            check("stall_op1", operand1, 32'd10);
            check("stall_op2", operand2, 32'd20);
            check("stall_rd", {27'b0, rd_address}, 32'd3);
        end
        step(0, 1, r_op(3, 2, 0), 1, 1, 2, 99, 0);
        check("bypass_op1", operand1, 32'd99);
        check("bypass_op2", operand2, 32'd0);
        step(0, 1, r_op(3, 1, 2), 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 55, 0);
        check("snoop_op1", operand1, 32'd55);
        check("snoop_op2", operand2, 32'd99);
        step(0, 0, 0, 1, 1, 0, 123, 0);
        step(0, 1, i_op(4, 0, 12'h000), 1, 0, 0, 0, 0);
        check("x0_op1", operand1, 32'd0);
        step(0, 1, {7'h00, 5'd2, 5'd1, 3'b000, 5'd0, 7'h63}, 1, 0, 0, 0, 0);
        check("illegal_flag", {31'b0, illegal}, 32'd1);
        check("illegal_op1", operand1, 32'd0);
        check("illegal_op2", operand2, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("flush_valid", {31'b0, decode_valid}, 32'd0);
        step(0, 1, r_op(6, 5, 5), 1, 0, 0, 0, 0);
        check("pre_reset_op1", operand1, 32'd7);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("reset_valid", {31'b0, decode_valid}, 32'd0);
        check("reset_op2", operand2, 32'd0);
        step(0, 1, r_op(6, 5, 5), 1, 0, 0, 0, 0);
        check("reset_x5", operand1, 32'd0);
        for (int k = 0; k < 600; k++) begin
            logic [31:0] ins;
            int          sel;
            sel           = $urandom_range(0, 9);
            ins           = $urandom;
            ins[6:0]      = sel < 4 ? 7'h33 : sel < 8 ? 7'h13 : 7'($urandom);
            ins[19:15]    = 5'($urandom_range(0, 7));
            ins[24:20]    = 5'($urandom_range(0, 7));
            step($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, ins, $urandom_range(0, 2) != 0,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 12) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
